// File: rtl/sar_search_if.sv
// sar_search_if -- handshake/compare bundle for sar_search.
//   start_i      : request a new search (driven by the requester)
//   above_i      : comparator response, trial_o > target
//   below_i      : comparator response, trial_o < target (both low = equal)
//   trial_o      : trial word under test
//   cmp_valid_o  : trial_o is under test, responses are consumed this edge
//   busy_o       : search in progress
//   done_o       : one-cycle completion pulse
//   result_o     : last search result, held until the next completion
//   exact_o      : equality seen during the last search
//   err_o        : above_i and below_i were both high during the last search
// WORD_WIDTH must match the WORD_WIDTH of the attached sar_search.
`timescale 1ns/1ps
interface sar_search_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic                  start_i;
  logic                  above_i;
  logic                  below_i;
  logic [WORD_WIDTH-1:0] trial_o;
  logic                  cmp_valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic [WORD_WIDTH-1:0] result_o;
  logic                  exact_o;
  logic                  err_o;

  // Requester / comparator side.
  modport master (
    output start_i, above_i, below_i,
    input  trial_o, cmp_valid_o, busy_o, done_o, result_o, exact_o, err_o
  );

  // Search engine side.
  modport slave (
    input  start_i, above_i, below_i,
    output trial_o, cmp_valid_o, busy_o, done_o, result_o, exact_o, err_o
  );
endinterface

// File: rtl/sar_search.sv
// sar_search -- successive-approximation search against an external comparator.
// Starting from the MSB, each TEST cycle presents trial_o = acc | (1<<k) and
// consumes one above_i/below_i response to decide bit k of the accumulator.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : asynchronous reset, active high
//   bus    : sar_search_if.slave (start/compare handshake and results)
// Parameters:
//   WORD_WIDTH : trial/result width, 1..32
//   EARLY_EXIT : 1 = finish on the first equal response, 0 = always WORD_WIDTH tests
`timescale 1ns/1ps
module sar_search #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sar_search_if.slave  bus
);

  localparam int unsigned KW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [KW-1:0]         idx_t;

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    DONE
  } state_e;

  state_e state_q, state_d;
  idx_t   k_q, k_d;
  word_t  acc_q, acc_d;
  word_t  trial_q, trial_d;
  word_t  result_q, result_d;
  logic   exact_q, exact_d;
  logic   err_q, err_d;

  // Per-test decode of the comparator response.
  idx_t   k_m1;
  word_t  bit_k;
  word_t  bit_next;
  word_t  acc_nxt;
  logic   resp_eq;
  logic   resp_both;

  always_comb begin
    k_m1      = k_q - idx_t'(1);
    bit_k     = word_t'(1) << k_q;
    bit_next  = word_t'(1) << k_m1;
    resp_eq   = ~bus.above_i & ~bus.below_i;
    resp_both = bus.above_i & bus.below_i;
    // Bit k is kept whenever the trial was not above the target
    // (below or equal); an above or contradictory response clears it.
    acc_nxt   = bus.above_i ? acc_q : (acc_q | bit_k);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    trial_d  = trial_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        trial_d = '0;
        if (bus.start_i) begin
          state_d = TEST;
          k_d     = idx_t'(WORD_WIDTH - 1);
          acc_d   = '0;
          trial_d = word_t'(1) << (WORD_WIDTH - 1);
          exact_d = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      TEST: begin
        acc_d = acc_nxt;
        if (resp_both) begin
          err_d = 1'b1;
        end
        if (resp_eq) begin
          exact_d = 1'b1;
        end

        if (resp_eq && (EARLY_EXIT != 0)) begin
          result_d = trial_q;
          state_d  = DONE;
          trial_d  = '0;
        end else if (k_q == '0) begin
          result_d = acc_nxt;
          state_d  = DONE;
          trial_d  = '0;
        end else begin
          k_d     = k_m1;
          trial_d = acc_nxt | bit_next;
        end
      end

      default: begin
        state_d = IDLE;
        trial_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial_o     = trial_q;
  assign bus.cmp_valid_o = (state_q == TEST);
  assign bus.busy_o      = (state_q == TEST);
  assign bus.done_o      = (state_q == DONE);
  assign bus.result_o    = result_q;
  assign bus.exact_o     = exact_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: width of trial and result words; legal range 1..32.
REQ-002 SHALL have parameter EARLY_EXIT, default 1: 1 = finish on first equal response; 0 = always run WORD_WIDTH tests.
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk_i input, 1 bit, rising-edge clock.
REQ-004 rst_i  input  1  asynchronous reset, active high.
REQ-005 start_i  input  1  request a new search; sampled on the rising clk_i edge.
REQ-006 above_i  input  1  external compare response: trial_o > target.
REQ-007 below_i  input  1  external compare response: trial_o < target; equal when both are low.
REQ-008 trial_o  output  WORD_WIDTH  registered trial word driven to the external comparator.
REQ-009 cmp_valid_o  output  1  high while trial_o is under test and above_i/below_i are consumed.
REQ-010 busy_o  output  1  high while a search is in progress.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 result_o  output  WORD_WIDTH  registered search result; holds until the next completion.
REQ-013 exact_o  output  1  equality was observed during the last search; valid with and after done_o.
REQ-014 err_o  output  1  sticky flag: above_i and below_i were both high during the last search.

Function
REQ-015 SHALL implement states IDLE, TEST and DONE; busy_o = cmp_valid_o = (state == TEST).
REQ-016 IDLE or DONE with start_i=1 -> TEST; on this transition bit index k = WORD_WIDTH-1, acc = 0, trial_o = 1<<k, and exact_o and err_o are cleared.
REQ-017 start_i while in TEST SHALL be ignored, with no effect on the search in progress.
REQ-018 Each TEST clock edge SHALL consume one response for trial_o = acc | (1<<k).
REQ-019 For below_i=1, above_i=0: acc bit k is set to 1.
REQ-020 For above_i=1: acc bit k stays 0.
REQ-021 For both above_i and below_i high: acc bit k stays 0 and err_o is set.
REQ-022 For both above_i and below_i low (equal): acc bit k is set to 1 and exact_o is set.
REQ-023 With EARLY_EXIT=1, an equal response SHALL load result_o = trial_o and move to DONE on that edge.
REQ-024 Otherwise, after the test with k=0, SHALL load result_o = final acc and move to DONE; while k>0, decrement k and update trial_o to the next trial.
REQ-025 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE, or to TEST if start_i=1 in that cycle; result_o, exact_o and err_o remain stable.
REQ-026 trial_o SHALL be 0 in IDLE and DONE.
REQ-027 Latency: done_o SHALL be high N cycles after the start edge, where N = number of tests (WORD_WIDTH, or fewer with early exit); minimum 1.
REQ-028 All arithmetic SHALL be unsigned, WORD_WIDTH bits, with no carries or overflow paths.
REQ-029 WORD_WIDTH=1 SHALL work with a single test (trial 1).

Reset
REQ-030 rst_i high, at any time including mid-TEST, SHALL immediately force: state IDLE, trial_o 0, cmp_valid_o 0, busy_o 0, done_o 0, result_o 0, exact_o 0, err_o 0.
REQ-031 An interrupted search SHALL NOT produce done_o after reset release; a new start_i is required.
REQ-032 start_i asserted in the first edge after reset release SHALL be accepted normally.

Verification
REQ-033 W=8, EARLY_EXIT=1, bench comparator against target 0xA5 -> trials 80,C0,A0,B0,A8,A4,A6,A5; done_o 8 cycles after start; result_o=0xA5, exact_o=1, err_o=0.
REQ-034 Target 0x80 -> single trial 0x80 equal; done_o 1 cycle after start; result_o=0x80, exact_o=1.
REQ-035 Target 0x00 (every response above) -> 8 tests, result_o=0x00, exact_o=0; separately, EARLY_EXIT=0 with target 0xFF -> trials 80,C0,...,FF; result_o=0xFF, exact_o=1, done_o after 8 cycles.
REQ-036 Force above_i=below_i=1 on the 3rd test of target 0x55 -> err_o=1 at done_o, and bit 5 of result_o = 0; err_o clears on the next start.
REQ-037 Assert rst_i during the 4th test -> all outputs 0 within the same cycle; no done_o follows.
REQ-038 Pulse start_i during TEST -> ignored; start_i during the DONE cycle -> next TEST begins with no IDLE cycle, and result_o holds until the new completion.
